noc_local_nic: RTL

NOC_LOCAL_NIC -- requirements
Module: noc_local_nic

---
 rtl/noc_local_nic_if.sv | 34 +++
 rtl/noc_local_nic.sv | 100 ++++++++++
 2 files changed

// File: rtl/noc_local_nic_if.sv
// Core-side and router-side signal bundle for the local NIC.
// slave is the NIC view, master is the core/router view.
interface noc_local_nic_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_dest;
    logic [7:0]  tx_payload;
    logic [15:0] net_data_o;
    logic        net_enable_o;
    logic        net_credit_i;
    logic [15:0] net_data_i;
    logic        net_enable_i;
    logic        net_credit_o;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic [1:0]  err;

    modport slave (
        input  tx_valid, tx_dest, tx_payload,
        input  net_credit_i, net_data_i, net_enable_i,
        input  rx_ready,
        output tx_ready, net_data_o, net_enable_o,
        output net_credit_o, rx_valid, rx_data, err
    );

    modport master (
        output tx_valid, tx_dest, tx_payload,
        output net_credit_i, net_data_i, net_enable_i,
        output rx_ready,
        input  tx_ready, net_data_o, net_enable_o,
        input  net_credit_o, rx_valid, rx_data, err
    );
endinterface

// File: rtl/noc_local_nic.sv
// Local NIC: credit-based flit injection into the router and
// an ejection FIFO that returns one credit per popped flit.
module noc_local_nic #(
    parameter logic [3:0] XCOORD   = 4'b1111,
    parameter logic [3:0] YCOORD   = 4'b1111,
    parameter int         CREDITS  = 4,
    parameter int         EJ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    noc_local_nic_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int NW = $clog2(EJ_DEPTH + 1);
    localparam int AW = (EJ_DEPTH > 1) ? $clog2(EJ_DEPTH) : 1;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [NW-1:0] EJ_FULL  = NW'(EJ_DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(EJ_DEPTH - 1);

    // Injection path
    logic [CW-1:0] credit_cnt;
    logic          accept;
    logic          cr_in;
    logic [15:0]   flit;
    logic          cred_ovf;

    assign bus.tx_ready = (credit_cnt != '0);
    assign accept       = bus.tx_valid && bus.tx_ready;
    assign cr_in        = bus.net_credit_i;
    assign flit         = {bus.tx_payload, bus.tx_dest};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt       <= CRED_MAX;
            bus.net_enable_o <= 1'b0;
            bus.net_data_o   <= 16'h0000;
            cred_ovf         <= 1'b0;
        end else begin
            bus.net_enable_o <= accept;
            if (accept)
                bus.net_data_o <= flit;
            unique case (1'b1)
                accept && !cr_in:
                    credit_cnt <= credit_cnt - 1'b1;
                !accept && cr_in && credit_cnt == CRED_MAX:
                    cred_ovf <= 1'b1;
                !accept && cr_in && credit_cnt != CRED_MAX:
                    credit_cnt <= credit_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Ejection path
    logic [15:0]   mem [EJ_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [NW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ej_ovf;

    assign full    = (count == EJ_FULL);
    assign pop     = bus.rx_valid && bus.rx_ready;
    // A full FIFO still takes a push when the head leaves this cycle
    assign push_ok = bus.net_enable_i && (!full || pop);

    assign bus.rx_valid = (count != '0);
    assign bus.rx_data  = mem[rp];
    assign bus.err      = {ej_ovf, cred_ovf};

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= bus.net_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp               <= '0;
            rp               <= '0;
            count            <= '0;
            bus.net_credit_o <= 1'b0;
            ej_ovf           <= 1'b0;
        end else begin
            bus.net_credit_o <= pop;
            if (push_ok)
                wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (pop && !push_ok)
                count <= count - 1'b1;
            if (bus.net_enable_i && full && !pop)
                ej_ovf <= 1'b1;
        end
    end
endmodule
